cigar_traceback: RTL and testbench

CIGAR_TRACEBACK -- requirements
Module: cigar_traceback

---
 rtl/cigar_traceback.sv | 133 +++++++++++++
 tb/tb_cigar_traceback.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cigar_traceback.sv
// Walks a backtrace matrix from (qlen,tlen) back to (0,0) and emits
// run-length-encoded CIGAR words (M/I/D) in traceback order.
module cigar_traceback #(
  parameter int BT_WIDTH  = 8,
  parameter int IDX_WIDTH = 12,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] qlen,
  input  logic [IDX_WIDTH-1:0] tlen,
  output logic                 bt_rd_en,
  output logic [IDX_WIDTH-1:0] bt_addr_i,
  output logic [IDX_WIDTH-1:0] bt_addr_j,
  input  logic [BT_WIDTH-1:0]  bt_data,
  output logic                 cigar_valid,
  input  logic                 cigar_ready,
  output logic [1:0]           cigar_op,
  output logic [LEN_WIDTH-1:0] cigar_len,
  output logic                 cigar_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, ISSUE, DEC, EMIT, FLUSH} state_t;
  localparam logic [1:0] OP_M = 2'd0, OP_I = 2'd1, OP_D = 2'd2;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  state_t               state;
  logic [IDX_WIDTH-1:0] i, j;
  logic [1:0]           run_op;
  logic [LEN_WIDTH-1:0] run_len;
  logic [1:0]           dec_op;
  logic                 dec_ill;

  // The read is issued in ISSUE so bt_data lands in DEC, giving a 2-cycle step.
  assign bt_rd_en  = (state == ISSUE) && (i != '0) && (j != '0);
  assign bt_addr_i = i;
  assign bt_addr_j = j;

  // On a matrix edge the op is forced and bt_data is not consulted.
  always_comb begin
    dec_op  = bt_data[2:1];
    dec_ill = 1'b0;
    if (i == '0)                dec_op = OP_D;
    else if (j == '0)           dec_op = OP_I;
    else if (bt_data[2:1] == 2'b11) dec_ill = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      run_op      <= OP_M;
      run_len     <= '0;
      cigar_valid <= 1'b0;
      cigar_op    <= OP_M;
      cigar_len   <= '0;
      cigar_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          i       <= qlen;
          j       <= tlen;
          run_len <= '0;
          err     <= 1'b0;
          busy    <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: state <= (i == '0 && j == '0) ? FLUSH : DEC;
        DEC: begin
          if (dec_ill) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (dec_op != OP_D) i <= i - 1'b1;
            if (dec_op != OP_I) j <= j - 1'b1;
            if (run_len == '0) begin
              run_op  <= dec_op;
              run_len <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
              state   <= ISSUE;
            end else if (dec_op == run_op && run_len != LEN_MAX) begin
              run_len <= run_len + 1'b1;
              state   <= ISSUE;
            end else begin
              cigar_op    <= run_op;
              cigar_len   <= run_len;
              cigar_last  <= 1'b0;
              cigar_valid <= 1'b1;
              run_op      <= dec_op;
              run_len     <= {{(LEN_WIDTH-1){1'b0}}, 1'b1};
              state       <= EMIT;
            end
          end
        end
        EMIT: if (cigar_ready) begin
          cigar_valid <= 1'b0;
          if (cigar_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= ISSUE;
          end
        end
        FLUSH: begin
          if (run_len != '0) begin
            cigar_op    <= run_op;
            cigar_len   <= run_len;
            cigar_last  <= 1'b1;
            cigar_valid <= 1'b1;
            state       <= EMIT;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cigar_traceback.sv
// Directed bench for cigar_traceback: a small backtrace memory model plus
// monitors for reads, emitted words and done pulses.
module tb_cigar_traceback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] qlen = '0, tlen = '0;
  logic        bt_rd_en;
  logic [11:0] bt_addr_i, bt_addr_j;
  logic [7:0]  bt_data = '0;
  logic        cigar_valid;
  logic        cigar_ready = 1'b1;
  logic [1:0]  cigar_op;
  logic [15:0] cigar_len;
  logic        cigar_last, busy, done, err;

  int total = 0, bad = 0;

  logic [7:0] mem [16][16];
  int   rd_i[$], rd_j[$];
  logic [1:0] w_op[$];
  int   w_len[$];
  logic w_last[$];
  int   done_cnt = 0;

  cigar_traceback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .qlen(qlen), .tlen(tlen),
    .bt_rd_en(bt_rd_en), .bt_addr_i(bt_addr_i), .bt_addr_j(bt_addr_j),
    .bt_data(bt_data), .cigar_valid(cigar_valid), .cigar_ready(cigar_ready),
    .cigar_op(cigar_op), .cigar_len(cigar_len), .cigar_last(cigar_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bt_rd_en) begin
      bt_data <= mem[bt_addr_i[3:0]][bt_addr_j[3:0]];
      rd_i.push_back(int'(bt_addr_i));
      rd_j.push_back(int'(bt_addr_j));
    end
    if (cigar_valid && cigar_ready) begin
      w_op.push_back(cigar_op);
      w_len.push_back(int'(cigar_len));
      w_last.push_back(cigar_last);
    end
    if (done) done_cnt++;
  end

  task automatic clear_all();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) mem[a][b] = 8'h00;
    rd_i.delete(); rd_j.delete();
    w_op.delete(); w_len.delete(); w_last.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int q, input int t);
    @(negedge clk);
    qlen = 12'(q); tlen = 12'(t); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (done_cnt == 0) begin
      bad++; $display("FAIL %s timeout: done never seen, required a done pulse", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_word(input string name, input int k,
                            input logic [1:0] op, input int len, input logic last);
    total++;
    if (w_op.size() <= k) begin
      bad++; $display("FAIL %s word%0d missing: got %0d words", name, k, w_op.size());
    end else if (w_op[k] !== op || w_len[k] != len || w_last[k] !== last) begin
      bad++; $display("FAIL %s word%0d got op=%0d len=%0d last=%0b, required op=%0d len=%0d last=%0b",
                      name, k, w_op[k], w_len[k], w_last[k], op, len, last);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++; $display("FAIL %s got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, err, cigar_valid, cigar_last, bt_rd_en} !== 6'b0 ||
        cigar_op !== 2'd0 || cigar_len !== 16'd0 || bt_addr_i !== 12'd0 || bt_addr_j !== 12'd0) begin
      bad++; $display("FAIL reset_outputs got busy=%b done=%b err=%b v=%b last=%b rd=%b op=%0d len=%0d ai=%0d aj=%0d, required all 0",
                      busy, done, err, cigar_valid, cigar_last, bt_rd_en, cigar_op, cigar_len, bt_addr_i, bt_addr_j);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_match3();
    clear_all();
    do_start(3, 3);
    wait_done("match3");
    check_int("match3_reads", rd_i.size(), 3);
    total++;
    if (rd_i.size() == 3 && !(rd_i[0] == 3 && rd_j[0] == 3 && rd_i[1] == 2 && rd_j[1] == 2 &&
                              rd_i[2] == 1 && rd_j[2] == 1)) begin
      bad++; $display("FAIL match3_addr got (%0d,%0d) (%0d,%0d) (%0d,%0d), required (3,3) (2,2) (1,1)",
                      rd_i[0], rd_j[0], rd_i[1], rd_j[1], rd_i[2], rd_j[2]);
    end
    check_int("match3_words", w_op.size(), 1);
    check_word("match3", 0, 2'd0, 3, 1'b1);
    check_int("match3_done", done_cnt, 1);
    check_int("match3_busy", int'(busy), 0);
  endtask

  task automatic test_mixed();
    clear_all();
    mem[2][4] = 8'b100; mem[2][3] = 8'b100;
    do_start(2, 4);
    wait_done("mixed");
    check_int("mixed_reads", rd_i.size(), 4);
    check_int("mixed_words", w_op.size(), 2);
    check_word("mixed", 0, 2'd2, 2, 1'b0);
    check_word("mixed", 1, 2'd0, 2, 1'b1);
  endtask

  task automatic test_edges();
    clear_all();
    do_start(2, 0);
    wait_done("ins");
    check_int("ins_reads", rd_i.size(), 0);
    check_int("ins_words", w_op.size(), 1);
    check_word("ins", 0, 2'd1, 2, 1'b1);
    clear_all();
    do_start(0, 0);
    wait_done("empty");
    check_int("empty_words", w_op.size(), 0);
    check_int("empty_done", done_cnt, 1);
  endtask

  task automatic test_stall();
    int n = 0;
    logic [1:0] op0; logic [15:0] len0; logic last0;
    clear_all();
    cigar_ready = 1'b0;
    do_start(3, 3);
    while (!cigar_valid && n < 100) begin @(negedge clk); n++; end
    op0 = cigar_op; len0 = cigar_len; last0 = cigar_last;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (!cigar_valid || cigar_op !== op0 || cigar_len !== len0 || cigar_last !== last0) begin
        bad++; $display("FAIL stall_hold cyc%0d got v=%b op=%0d len=%0d last=%b, required v=1 op=%0d len=%0d last=%b",
                        c, cigar_valid, cigar_op, cigar_len, cigar_last, op0, len0, last0);
      end
    end
    cigar_ready = 1'b1;
    wait_done("stall");
    check_int("stall_words", w_op.size(), 1);
    check_word("stall", 0, 2'd0, 3, 1'b1);
  endtask

  task automatic test_err();
    int v_seen = 0;
    clear_all();
    mem[3][3] = 8'b110;
    do_start(3, 3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cigar_valid) v_seen++;
    end
    check_int("err_flag", int'(err), 1);
    check_int("err_done", done_cnt, 1);
    check_int("err_valid", v_seen, 0);
    check_int("err_words", w_op.size(), 0);
    clear_all();
    do_start(0, 0);
    check_int("err_clear", int'(err), 0);
    wait_done("err_clear");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_all();
    cigar_ready = 1'b0;
    do_start(3, 3);
    while (!cigar_valid && n < 100) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, cigar_valid, cigar_last, bt_rd_en} !== 6'b0 || cigar_len !== 16'd0) begin
      bad++; $display("FAIL midreset_outputs got busy=%b v=%b last=%b len=%0d, required all 0",
                      busy, cigar_valid, cigar_last, cigar_len);
    end
    @(negedge clk); rst_n = 1'b1; cigar_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_int("midreset_words", w_op.size(), 0);
    check_int("midreset_busy", int'(busy), 0);
    do_start(3, 3);
    wait_done("midreset_restart");
    check_int("midreset_restart_words", w_op.size(), 1);
    check_word("midreset_restart", 0, 2'd0, 3, 1'b1);
  endtask

  initial begin
    test_reset();
    test_match3();
    test_mixed();
    test_edges();
    test_stall();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
